// File: rtl/alu_pkg.sv
// alu_pkg: opcode and FSM state types shared by alu_iter, its interface and bench.
package alu_pkg;

  typedef enum logic [2:0] {
    ADD_OP = 3'd0,
    SUB_OP = 3'd1,
    AND_OP = 3'd2,
    OR_OP  = 3'd3,
    XOR_OP = 3'd4,
    MUL_OP = 3'd5
  } alu_op_e;

  // IDLE: nothing held; BUSY: multiplier iterating; DONE: result held on the output port
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_iter_if.sv
// alu_iter_if: operation input port and result output port of alu_iter.
// Handshake: a transfer happens on a rising clk edge where valid && ready are both
// high; the sender holds its payload stable while valid is high and ready is low.
interface alu_iter_if #(
  parameter int WIDTH = 8
);
  import alu_pkg::*;

  logic             in_valid;
  logic             in_ready;
  alu_op_e          in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [WIDTH-1:0] out_result_hi;
  logic             out_carry;
  logic             out_zero;
  logic             out_err;

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_result, out_result_hi, out_carry, out_zero, out_err
  );

  modport master (
    output in_valid, in_op, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_result, out_result_hi, out_carry, out_zero, out_err
  );

endinterface

// File: rtl/alu_iter_mul.sv
// alu_mul_iter: unsigned shift-add multiplier, one partial product per cycle.
// Only present when ALU_ITER_MUL_EN is defined.
`ifdef ALU_ITER_MUL_EN
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_busy,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_prod
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic               r_busy;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] w_acc_next;

  // Accumulator after the current step; on the last step this is the full product.
  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign o_done     = r_busy && (r_cnt == CW'(WIDTH - 1));
  assign o_busy     = r_busy;
  assign o_prod     = w_acc_next;

  // Load operands on start, then add-and-shift once per cycle for WIDTH cycles.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (i_start) begin
      r_busy   <= 1'b1;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_mplier <= i_b;
    end else if (r_busy) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      if (o_done) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule
`endif

// File: rtl/alu_iter.sv
// alu_iter: handshaked ALU with a registered result/flags stage.
// Build option: define ALU_ITER_MUL_EN to make MUL legal and include the iterative
// multiplier; without it MUL reports out_err like any other unused opcode.
module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  alu_iter_if.slave   bus,
  output alu_state_e  o_state
);

  alu_state_e r_state;
  alu_state_e w_next_state;

  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_result_hi;
  logic             r_carry;
  logic             r_zero;
  logic             r_err;

  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_accept;
  logic             w_is_mul;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;
  logic             w_err;
  logic             w_zero;

  logic               w_mul_busy;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_mul_prod;

  assign w_accept = bus.in_valid && w_in_ready;

`ifdef ALU_ITER_MUL_EN
  assign w_is_mul = (bus.in_op == MUL_OP);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (w_accept && w_is_mul),
    .i_a     (bus.in_a),
    .i_b     (bus.in_b),
    .o_busy  (w_mul_busy),
    .o_done  (w_mul_done),
    .o_prod  (w_mul_prod)
  );
`else
  assign w_is_mul   = 1'b0;
  assign w_mul_busy = 1'b0;
  assign w_mul_done = 1'b0;
  assign w_mul_prod = '0;
`endif

  // Single-cycle datapath; SUB borrow is the top bit of the (WIDTH+1)-bit difference.
  assign w_sum  = {1'b0, bus.in_a} + {1'b0, bus.in_b} + {{WIDTH{1'b0}}, bus.in_cin};
  assign w_diff = {1'b0, bus.in_a} - {1'b0, bus.in_b} - {{WIDTH{1'b0}}, bus.in_cin};

  // Opcode decode for non-MUL results; unused encodings raise err with all else 0.
  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_err   = 1'b0;
    case (bus.in_op)
      ADD_OP: {w_carry, w_res} = w_sum;
      SUB_OP: {w_carry, w_res} = w_diff;
      AND_OP: w_res = bus.in_a & bus.in_b;
      OR_OP:  w_res = bus.in_a | bus.in_b;
      XOR_OP: w_res = bus.in_a ^ bus.in_b;
      default: w_err = 1'b1;
    endcase
    w_zero = !w_err && (w_res == '0);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic; DONE retires and can accept a new op on the same edge.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next_state = w_is_mul ? BUSY : DONE;
      BUSY: begin
        if (w_mul_done)      w_next_state = DONE;
        else if (!w_mul_busy) w_next_state = IDLE;
      end
      DONE: begin
        if (bus.out_ready) begin
          if (w_accept) w_next_state = w_is_mul ? BUSY : DONE;
          else          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Handshake outputs; in_ready looks through to out_ready while a result is held.
  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      IDLE: w_in_ready = 1'b1;
      DONE: begin
        w_out_valid = 1'b1;
        w_in_ready  = bus.out_ready;
      end
      default: ;
    endcase
  end

  // Result/flag registers: load on an accepted single-cycle op or on multiplier completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result    <= '0;
      r_result_hi <= '0;
      r_carry     <= 1'b0;
      r_zero      <= 1'b0;
      r_err       <= 1'b0;
    end else if (w_accept && !w_is_mul) begin
      r_result    <= w_res;
      r_result_hi <= '0;
      r_carry     <= w_carry;
      r_zero      <= w_zero;
      r_err       <= w_err;
    end else if (w_mul_done) begin
      r_result    <= w_mul_prod[WIDTH-1:0];
      r_result_hi <= w_mul_prod[2*WIDTH-1:WIDTH];
      r_carry     <= 1'b0;
      r_zero      <= (w_mul_prod == '0);
      r_err       <= 1'b0;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = w_out_valid;
  assign bus.out_result = r_result;
`ifdef ALU_ITER_MUL_EN
  assign bus.out_result_hi = r_result_hi;
`else
  assign bus.out_result_hi = '0;
`endif
  assign bus.out_carry  = r_carry;
  assign bus.out_zero   = r_zero;
  assign bus.out_err    = r_err;
  assign o_state        = r_state;

endmodule

// File: doc/alu_iter.md
# alu_iter

Parametrised, handshaked successor to the team's combinational 8-bit ALU. It accepts one operation per transfer on a valid/ready input port and returns a registered result with flags on a valid/ready output port. Single-cycle logic/arithmetic ops have throughput one; an optional iterative shift-add multiplier provides a multi-cycle MUL. It sits between an operand-issue stage and a writeback stage that may apply backpressure.

## Interface
- WIDTH, 8, operand and result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operation offered
- in_ready  output  1  operation accepted when in_valid && in_ready at the clk edge
- in_op  input  alu_op_e (3)  opcode
- in_a, in_b  input  WIDTH  operands
- in_cin  input  1  carry-in (ADD) / borrow-in (SUB); ignored otherwise
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out_result  output  WIDTH  result (MUL: low half)
- out_result_hi  output  WIDTH  MUL high half; 0 for other ops
- out_carry  output  1  ADD carry-out / SUB borrow-out; 0 otherwise
- out_zero  output  1  out_result == 0 (MUL: full 2*WIDTH product == 0)
- out_err  output  1  illegal opcode; out_result = 0
- One clock; reset is synchronous and active-high.

## Operation
- ADD: {out_carry,out_result} = in_a + in_b + in_cin, WIDTH+1-bit sum.
- SUB: out_result = (in_a − in_b − in_cin) mod 2^WIDTH; out_carry = 1 iff in_a < in_b + in_cin (borrow).
- AND, OR, XOR: bitwise; out_carry = 0.
- MUL: unsigned, {out_result_hi,out_result} = in_a * in_b, 2*WIDTH bits.
- Unused encodings: out_err = 1, all other outputs 0, single-cycle.
- FSM: IDLE (no result held), BUSY (MUL iterating), DONE (result held, out_valid = 1).
- IDLE → DONE on accepted non-MUL op; IDLE → BUSY on accepted MUL.
- BUSY: one shift-add step per cycle, counter 0..WIDTH−1 ($clog2(WIDTH) bits); last step → DONE. in_ready = 0 in BUSY.
- DONE with out_ready = 1: result retired; same edge accepts a new op if in_valid (→ DONE or BUSY), else → IDLE.
- DONE with out_ready = 0: all out_* held stable, in_ready = 0.
- in_ready = (state == IDLE) || (state == DONE && out_ready) — combinational from out_ready.

## Timing
- Reset: state IDLE; out_valid 0, in_ready 1 after reset deassertion; out_result, out_result_hi, out_carry, out_zero, out_err all 0; counter 0.
- Non-MUL latency: accepted at edge N → out_valid high after edge N (visible cycle N+1). Back-to-back throughput 1/cycle with out_ready held high.
- MUL latency: accepted at edge N → out_valid after edge N+WIDTH.
- Reset mid-MUL or while DONE: operation dropped, no out_valid pulse, returns to IDLE.
- Operands are registered on acceptance; in_a/in_b may change freely afterwards.

## Configuration
- ALU_ITER_MUL_EN defined: MUL opcode legal, BUSY state and multiplier instantiated.
- Not defined: MUL treated as illegal opcode (out_err = 1, single-cycle), BUSY unreachable, out_result_hi tied 0, no multiplier logic.

## Structure
- alu_pkg: alu_op_e enum (ADD_OP=0, SUB_OP=1, AND_OP=2, OR_OP=3, XOR_OP=4, MUL_OP=5), alu_state_e (IDLE, BUSY, DONE).
- Sub-module alu_mul_iter #(WIDTH): start/busy/done, shift-add accumulator, guarded by ALU_ITER_MUL_EN.

## Test plan
- WIDTH=8, ADD 10+8 cin 0, out_ready=1 → next cycle out_result 18, carry 0, zero 0.
- ADD 255+1 cin 0 → out_result 0, carry 1, zero 1; SUB 9−3 cin 1 → 5, carry 0; SUB 3−9 cin 0 → 250, carry 1.
- AND 4&7 → 4; OR 8|6 → 14; XOR 0xAA^0xFF → 0x55; opcode 7 → out_err 1, result 0.
- MUL 200*3 (macro defined) → out_valid after 8 cycles, hi 0x02, lo 0x58; in_ready 0 throughout BUSY; undefined macro → out_err 1 next cycle.
- Backpressure: out_ready=0 for 5 cycles after ADD → outputs stable, in_ready 0; raise out_ready with new op on in → retire and accept same edge.
- Assert rst mid-MUL → next cycle IDLE, out_valid 0, in_ready 1, all outputs 0; next ADD completes normally.
